// File: rtl/keypad_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_ctrl -- debounced key-press detector with event FIFO and register bus
// Revision 1.0
// ============================================================================
module keypad_ctrl #(
   parameter int DEBOUNCE_CYCLES = 100000,
   parameter int RELEASE_CYCLES  = 1100000,
   parameter int FIFO_DEPTH      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_code,
   input  logic        key_valid,
   input  logic        sel,
   input  logic        rd,
   input  logic        wr,
   input  logic [1:0]  addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        irq
);

   localparam int MAX_CYC = (RELEASE_CYCLES > DEBOUNCE_CYCLES) ? RELEASE_CYCLES : DEBOUNCE_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam int AW      = $clog2(FIFO_DEPTH);

   // Thresholds are "last count before the transition", so the transition
   // lands on the Nth qualifying cycle counted from the IDLE/HELD exit.
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_CYCLES - 1);
   localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] HELD     = 2'd2;
   localparam logic [1:0] RELEASE  = 2'd3;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    cand;

   logic          enable;
   logic          irq_en;
   logic          overflow;

   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;

   logic bus_rd, bus_wr;
   logic data_rd, stat_wr, ctrl_wr;
   logic flush, ovf_clr;
   logic not_empty, full;
   logic push_req, push_ok, pop, ovf_set;
   logic unused_wdata;

   assign bus_rd    = sel & rd;
   assign bus_wr    = sel & wr;
   assign data_rd   = bus_rd & (addr == 2'd0);
   assign stat_wr   = bus_wr & (addr == 2'd1);
   assign ctrl_wr   = bus_wr & (addr == 2'd2);
   assign flush     = stat_wr & wdata[3];
   assign ovf_clr   = stat_wr & wdata[2];

   assign not_empty = (count != '0);
   assign full      = (count == DEPTH);

   assign push_req  = enable && (state == DEBOUNCE) && key_valid &&
                      (key_code == cand) && (cnt >= DEB_LAST);
   assign pop       = data_rd & not_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok   = push_req & ~flush & (~full | pop);
   assign ovf_set   = push_req & ~flush & full & ~pop;

   assign unused_wdata = &{1'b0, wdata[15:4]};

   // ------------------------------------------------------------------
   // Press FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         cand  <= 4'h0;
      end else if (!enable) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (key_valid) begin
                  state <= DEBOUNCE;
                  cand  <= key_code;
                  cnt   <= CW'(1);
               end
            end
            DEBOUNCE: begin
               if (!key_valid || key_code != cand) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt >= DEB_LAST) begin
                  state <= HELD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            HELD: begin
               if (!key_valid) begin
                  state <= RELEASE;
                  cnt   <= CW'(1);
               end
            end
            RELEASE: begin
               // Any key seen during the release window is the same press
               // bouncing or a neighbour key; neither creates a new event.
               if (key_valid) begin
                  state <= HELD;
                  cnt   <= '0;
               end else if (cnt >= REL_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Event FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wptr] <= cand;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) begin
            wptr <= wptr + AW'(1);
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         count <= count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      end
   end

   // ------------------------------------------------------------------
   // Control / status registers and interrupt
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         enable <= 1'b1;
         irq_en <= 1'b0;
      end else if (ctrl_wr) begin
         enable <= wdata[0];
         irq_en <= wdata[1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         irq <= 1'b0;
      end else begin
         irq <= irq_en & not_empty;
      end
   end

   always_comb begin
      rdata = 16'h0000;
      if (bus_rd) begin
         case (addr)
            2'd0: begin
               if (not_empty) begin
                  rdata[15]  = 1'b1;
                  rdata[3:0] = mem[rptr];
               end
            end
            2'd1: begin
               rdata[0]     = not_empty;
               rdata[1]     = full;
               rdata[2]     = overflow;
               rdata[8:4]   = 5'(count);
               rdata[11:10] = state;
            end
            2'd2: begin
               rdata[0] = enable;
               rdata[1] = irq_en;
            end
            default: rdata = 16'h0000;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_keypad_ctrl.sv
`default_nettype none
// tb_keypad_ctrl -- randomized and directed checks of keypad_ctrl against a
// press-level model (press length vs. debounce threshold, queue for the FIFO).
module tb_keypad_ctrl;

   localparam int D = 4;
   localparam int R = 8;
   localparam int F = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_code = 4'h0;
   logic        key_valid = 1'b0;
   logic        sel = 1'b0;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  addr = 2'd0;
   logic [15:0] wdata = 16'h0;
   logic [15:0] rdata;
   logic        irq;

   int checks = 0;
   int failures = 0;

   logic [3:0]  q[$];
   bit          ovf_m = 1'b0;
   logic [15:0] v;

   keypad_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .RELEASE_CYCLES (R),
      .FIFO_DEPTH     (F)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .key_code (key_code),
      .key_valid(key_valid),
      .sel      (sel),
      .rd       (rd),
      .wr       (wr),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic keys(input logic kv, input logic [3:0] kc, input int n);
      key_valid = kv;
      key_code  = kc;
      step(n);
   endtask

   task automatic peek(input logic [1:0] a, output logic [15:0] val);
      sel = 1'b1; rd = 1'b1; addr = a;
      #1 val = rdata;
      sel = 1'b0; rd = 1'b0;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [15:0] val);
      sel = 1'b1; rd = 1'b1; addr = a;
      #1 val = rdata;
      step(1);
      sel = 1'b0; rd = 1'b0;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [15:0] d);
      sel = 1'b1; wr = 1'b1; addr = a; wdata = d;
      step(1);
      sel = 1'b0; wr = 1'b0; wdata = 16'h0;
   endtask

   function automatic logic [15:0] exp_status(input logic [1:0] st);
      logic [15:0] s;
      s        = 16'h0;
      s[0]     = (q.size() != 0);
      s[1]     = (q.size() == F);
      s[2]     = ovf_m;
      s[8:4]   = 5'(q.size());
      s[11:10] = st;
      return s;
   endfunction

   function automatic void model_event(input logic [3:0] c);
      if (q.size() < F) q.push_back(c);
      else ovf_m = 1'b1;
   endfunction

   function automatic logic [15:0] model_pop();
      logic [15:0] r;
      r = 16'h0;
      if (q.size() != 0) begin
         r[15]  = 1'b1;
         r[3:0] = q.pop_front();
      end
      return r;
   endfunction

   // One full press: high for h cycles, optional bounce, then a full release.
   task automatic press(input logic [3:0] c, input int h, input bit bounce);
      keys(1'b1, c, h);
      if (h >= D && bounce) begin
         keys(1'b0, c, $urandom_range(1, R - 1));
         keys(1'b1, 4'($urandom_range(0, 15)), $urandom_range(1, 5));
      end
      keys(1'b0, c, R + $urandom_range(0, 3));
      if (h >= D) model_event(c);
   endtask

   task automatic drain();
      while (q.size() != 0) begin
         rd_reg(2'd0, v);
         check("drain_data", v, model_pop());
      end
   endtask

   initial begin
      step(2);
      rst = 1'b0;

      // Reset state
      peek(2'd1, v); check("rst_status", v, 16'h0000);
      peek(2'd2, v); check("rst_ctrl", v, 16'h0001);
      peek(2'd0, v); check("rst_data", v, 16'h0000);
      check("rst_irq", {15'h0, irq}, 16'h0);

      // Single press, code 5
      keys(1'b1, 4'h5, 10);
      keys(1'b0, 4'h5, 10);
      model_event(4'h5);
      peek(2'd1, v); check("p5_status", v, exp_status(2'd0));
      rd_reg(2'd0, v); check("p5_data", v, 16'h8005);
      void'(model_pop());
      peek(2'd1, v); check("p5_empty", {15'h0, v[0]}, 16'h0);

      // Too-short press
      keys(1'b1, 4'h7, 3);
      peek(2'd1, v); check("short_deb", v, 16'h0400);
      keys(1'b0, 4'h7, 1);
      peek(2'd1, v); check("short_idle", v, 16'h0000);

      // Bouncy hold of A: one event only
      for (int i = 0; i < 4; i++) begin
         keys(1'b1, 4'hA, 5);
         keys(1'b0, 4'hA, 6);
      end
      model_event(4'hA);
      peek(2'd1, v); check("bounce_rel", v, exp_status(2'd3));
      keys(1'b0, 4'hA, 9);
      peek(2'd1, v); check("bounce_idle", v, exp_status(2'd0));
      drain();

      // Six presses, no reads -> overflow
      for (int i = 1; i <= 6; i++) press(4'(i), 5, 1'b0);
      peek(2'd1, v); check("ovf_status", v, 16'h0047);
      check("ovf_model", v, exp_status(2'd0));
      // Overflow set beats same-cycle clear
      keys(1'b1, 4'hE, D - 1);
      wr_reg(2'd1, 16'h0004);
      model_event(4'hE);
      keys(1'b0, 4'hE, R);
      peek(2'd1, v); check("ovf_set_wins", v, exp_status(2'd0));
      for (int i = 1; i <= 4; i++) begin
         rd_reg(2'd0, v); check("ovf_data", v, 16'h8000 | 16'(i));
         void'(model_pop());
      end
      rd_reg(2'd0, v); check("ovf_empty", v, 16'h0000);
      wr_reg(2'd1, 16'h0004);
      ovf_m = 1'b0;
      peek(2'd1, v); check("ovf_clear", v, 16'h0000);

      // Interrupt
      wr_reg(2'd2, 16'h0003);
      peek(2'd2, v); check("ctrl_rb", v, 16'h0003);
      keys(1'b1, 4'h9, D);
      model_event(4'h9);
      check("irq_lag", {15'h0, irq}, 16'h0);
      keys(1'b1, 4'h9, 1);
      check("irq_set", {15'h0, irq}, 16'h1);
      keys(1'b0, 4'h9, R);
      rd_reg(2'd0, v); check("irq_data", v, model_pop());
      check("irq_hold", {15'h0, irq}, 16'h1);
      step(1);
      check("irq_clr", {15'h0, irq}, 16'h0);
      wr_reg(2'd2, 16'h0001);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < F; i++) press(4'(8 + i), D, 1'b0);
      keys(1'b1, 4'h3, D - 1);
      sel = 1'b1; rd = 1'b1; addr = 2'd0;
      #1 v = rdata;
      step(1);
      sel = 1'b0; rd = 1'b0;
      check("pp_data", v, model_pop());
      model_event(4'h3);
      keys(1'b0, 4'h3, R);
      peek(2'd1, v); check("pp_status", v, exp_status(2'd0));

      // Flush beats same-cycle push
      keys(1'b1, 4'h4, D - 1);
      wr_reg(2'd1, 16'h0008);
      q.delete();
      peek(2'd1, v); check("flush_status", v, exp_status(2'd2));
      keys(1'b0, 4'h4, R);

      // Disable: FSM forced idle, no pushes, contents kept
      press(4'hB, D, 1'b0);
      keys(1'b1, 4'h6, 2);
      wr_reg(2'd2, 16'h0000);
      step(1);
      peek(2'd1, v); check("dis_idle", v, exp_status(2'd0));
      keys(1'b1, 4'h6, 8);
      peek(2'd1, v); check("dis_nopush", v, exp_status(2'd0));
      keys(1'b0, 4'h6, 2);
      wr_reg(2'd2, 16'h0001);
      drain();

      // Reset while held: pending press dropped, re-debounced after reset
      keys(1'b1, 4'h3, D + 2);
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      q.delete(); ovf_m = 1'b0;
      peek(2'd1, v); check("rstheld_status", v, 16'h0000);
      step(D - 1);
      peek(2'd1, v); check("rstheld_deb", v, exp_status(2'd1));
      step(1);
      model_event(4'h3);
      peek(2'd1, v); check("rstheld_push", v, exp_status(2'd2));
      keys(1'b0, 4'h3, R);
      drain();

      // Randomized presses with occasional reads
      for (int i = 0; i < 30; i++) begin
         press(4'($urandom_range(0, 15)), $urandom_range(1, 8), 1'($urandom_range(0, 1)));
         peek(2'd1, v); check("rnd_status", v, exp_status(2'd0));
         if ($urandom_range(0, 2) != 0) begin
            rd_reg(2'd0, v); check("rnd_data", v, model_pop());
         end
      end
      drain();
      peek(2'd1, v); check("end_status", v, exp_status(2'd0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
